// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer that owns the HI/LO result pair.
// One shift-add or restoring-divide step per cycle, committed to HI/LO in FINISH.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [2:0]           op_code,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [WIDTH-1:0]     hi_out,
  output logic [WIDTH-1:0]     lo_out,
  output logic [2*WIDTH-1:0]   hilo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b011;
  localparam logic [2:0] OP_MTLO  = 3'b100;
  localparam logic [2:0] OP_CLR   = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic [CW-1:0]        count;
  logic                 dbz_pend;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic [WIDTH-1:0]     mul_addend;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic                 last_step;

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV,
  // so both ops finish with {HI, LO} sitting in acc.
  always_comb begin
    mul_addend = acc[0] ? opnd : '0;
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    div_trial  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    last_step  = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      opnd        <= '0;
      count       <= '0;
      dbz_pend    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_MULTU: begin
                acc      <= {{WIDTH{1'b0}}, src_b};
                opnd     <= src_a;
                count    <= '0;
                dbz_pend <= 1'b0;
                state    <= MUL;
              end
              OP_DIVU: begin
                if (src_b == '0) begin
                  dbz_pend <= 1'b1;
                  state    <= FINISH;
                end else begin
                  acc      <= {{WIDTH{1'b0}}, src_a};
                  opnd     <= src_b;
                  count    <= '0;
                  dbz_pend <= 1'b0;
                  state    <= DIV;
                end
              end
              OP_MTHI: begin
                hi_q <= src_a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo_q <= src_a;
                done <= 1'b1;
              end
              OP_CLR: begin
                hi_q <= '0;
                lo_q <= '0;
                done <= 1'b1;
              end
              default: done <= 1'b1;
            endcase
          end
        end
        MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          count <= count + CW'(1);
          if (last_step) state <= FINISH;
        end
        DIV: begin
          // A borrow out of the trial subtract means the divisor did not fit: restore.
          acc   <= {(div_trial[WIDTH] ? acc[2*WIDTH-2:WIDTH-1] : div_trial[WIDTH-1:0]),
                    acc[WIDTH-2:0], ~div_trial[WIDTH]};
          count <= count + CW'(1);
          if (last_step) state <= FINISH;
        end
        FINISH: begin
          if (dbz_pend) begin
            div_by_zero <= 1'b1;
          end else begin
            hi_q <= acc[2*WIDTH-1:WIDTH];
            lo_q <= acc[WIDTH-1:0];
          end
          dbz_pend <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign op_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign hilo     = {hi_q, lo_q};

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a scoreboard queue of expected HI/LO results,
// filled when an op is driven and drained when done pulses.
module tb_muldiv_seq;

  localparam int W = 32;

  localparam logic [2:0] NOP   = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIVU  = 3'b010;
  localparam logic [2:0] MTHI  = 3'b011;
  localparam logic [2:0] MTLO  = 3'b100;
  localparam logic [2:0] CLR   = 3'b101;

  logic           clk;
  logic           reset;
  logic           op_valid;
  logic           op_ready;
  logic [2:0]     op_code;
  logic [W-1:0]   src_a;
  logic [W-1:0]   src_b;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [W-1:0]   hi_out;
  logic [W-1:0]   lo_out;
  logic [2*W-1:0] hilo;

  typedef struct {
    logic [2*W-1:0] hilo;
    logic           dbz;
    int             lat;
  } exp_t;

  exp_t        sb[$];
  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;
  int          errors;
  int          checks;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .hilo        (hilo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point: counts it, and on mismatch counts the failure and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: updates the architectural HI/LO and queues what done should show.
  task automatic pushExpect(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] prod;
    e.dbz = 1'b0;
    e.lat = 0;
    case (code)
      MULTU: begin
        prod = 64'(a) * 64'(b);
        model_hi = prod[63:32];
        model_lo = prod[31:0];
        e.lat = W + 1;
      end
      DIVU: begin
        if (b == 0) begin
          e.dbz = 1'b1;
          e.lat = 1;
        end else begin
          model_hi = a % b;
          model_lo = a / b;
          e.lat = W + 1;
        end
      end
      MTHI: model_hi = a;
      MTLO: model_lo = a;
      CLR: begin
        model_hi = '0;
        model_lo = '0;
      end
      default: ;
    endcase
    e.hilo = {model_hi, model_lo};
    sb.push_back(e);
  endtask

  // Drives one op for exactly its accept edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    checkOutput("ready_before_op", {63'b0, op_ready}, 64'd1);
    pushExpect(code, a, b);
    op_valid = 1'b1;
    op_code  = code;
    src_a    = a;
    src_b    = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  // Waits (bounded) for done, then checks latency, busy span and the committed result.
  task automatic waitDone(input string tag);
    exp_t e;
    int n;
    int bc;
    n  = 0;
    bc = busy ? 1 : 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) bc++;
    end
    if (sb.size() == 0) begin
      checkOutput({tag, "_scoreboard_nonempty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_done_seen"}, {63'b0, done}, 64'd1);
    checkOutput({tag, "_latency"}, 64'(n), 64'(e.lat));
    checkOutput({tag, "_busy_cycles"}, 64'(bc), 64'(e.lat));
    checkOutput({tag, "_hilo"}, hilo, e.hilo);
    checkOutput({tag, "_hi_lo_ports"}, {hi_out, lo_out}, e.hilo);
    checkOutput({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, e.dbz});
    checkOutput({tag, "_ready_at_done"}, {63'b0, op_ready}, 64'd1);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    model_hi = '0;
    model_lo = '0;
    reset    = 1'b0;
    op_valid = 1'b0;
    op_code  = NOP;
    src_a    = '0;
    src_b    = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("idle_hilo", hilo, 64'd0);
      checkOutput("idle_ready", {63'b0, op_ready}, 64'd1);
      checkOutput("idle_busy", {63'b0, busy}, 64'd0);
      checkOutput("idle_done", {63'b0, done}, 64'd0);
      @(posedge clk);
      #1;
    end

    // Largest product, then confirm done was a single pulse
    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("mul_max");
    @(posedge clk);
    #1;
    checkOutput("mul_max_done_single", {63'b0, done}, 64'd0);
    checkOutput("mul_max_hilo_stable", hilo, 64'hFFFF_FFFE_0000_0001);

    applyStimulus(DIVU, 32'd100, 32'd7);
    waitDone("div_100_7");

    // Preset HI/LO, then divide by zero must leave them alone
    applyStimulus(MTHI, 32'hDEAD_BEEF, 32'd0);
    waitDone("mthi");
    applyStimulus(MTLO, 32'h1234_5678, 32'd0);
    waitDone("mtlo");
    applyStimulus(DIVU, 32'd5, 32'd0);
    waitDone("div_by_zero");
    @(posedge clk);
    #1;
    checkOutput("dbz_single", {63'b0, div_by_zero}, 64'd0);

    // Abort an in-flight divide with reset at iteration 10
    op_valid = 1'b1;
    op_code  = DIVU;
    src_a    = 32'hFFFF_FFFF;
    src_b    = 32'd3;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("abort_busy_mid", {63'b0, busy}, 64'd1);
    checkOutput("abort_hilo_stable", hilo, 64'hDEAD_BEEF_1234_5678);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_hi = '0;
    model_lo = '0;
    checkOutput("abort_hilo_cleared", hilo, 64'd0);
    checkOutput("abort_idle", {63'b0, op_ready}, 64'd1);
    checkOutput("abort_no_done", {63'b0, done}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_no_done_after", {63'b0, done}, 64'd0);

    applyStimulus(MULTU, 32'd6, 32'd7);
    waitDone("mul_6_7");

    // MTLO held through a busy MULTU: taken only in the done cycle
    applyStimulus(MULTU, 32'd3, 32'd4);
    op_valid = 1'b1;
    op_code  = MTLO;
    src_a    = 32'hA5A5_A5A5;
    src_b    = '0;
    waitDone("mul_3_4_held_mtlo");
    pushExpect(MTLO, 32'hA5A5_A5A5, 32'd0);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    waitDone("held_mtlo");

    // Remaining codes and divide/multiply boundaries, issued back-to-back
    applyStimulus(3'b111, 32'h1111_1111, 32'h2222_2222);
    waitDone("undef_nop");
    applyStimulus(CLR, 32'd0, 32'd0);
    waitDone("clr");
    applyStimulus(NOP, 32'd9, 32'd9);
    waitDone("nop");
    applyStimulus(DIVU, 32'd7, 32'd100);
    waitDone("div_small_by_big");
    applyStimulus(DIVU, 32'hFFFF_FFFF, 32'd1);
    waitDone("div_by_one");
    applyStimulus(DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("div_big_divisor");
    applyStimulus(MULTU, 32'd0, 32'h1234_5678);
    waitDone("mul_zero");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(MULTU, $urandom, $urandom);
      waitDone("mul_rand");
      applyStimulus(DIVU, $urandom, $urandom_range(1, 32'h7FFF_FFFF) >> $urandom_range(0, 30));
      waitDone("div_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
